// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared sizes and FSM state type for the memory arbiter.
// Imported by mem_arbiter and arb_burst_counter.
package mem_arbiter_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W      = 16;
  localparam int OFF_W       = $clog2(BLOCK_WORDS);
  localparam int CNT_W       = OFF_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    IC_FILL,
    DC_FILL,
    DC_WRITE
  } state_t;

endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: issue and receive word counters for one block burst.
// Ports: i_clk, i_rst (sync, high), i_clear, i_run (fill state),
//   i_data_valid, o_issue/o_recv (word index), o_issue_active, o_recv_last.
module arb_burst_counter
  import mem_arbiter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_data_valid,
  output logic [OFF_W-1:0] o_issue,
  output logic [OFF_W-1:0] o_recv,
  output logic             o_issue_active,
  output logic             o_recv_last
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

  logic [CNT_W-1:0] r_issue;
  logic [CNT_W-1:0] r_recv;
  logic             w_issue_inc;
  logic             w_recv_inc;

  assign o_issue_active = (r_issue < FULL);
  assign w_issue_inc    = i_run & o_issue_active;
  // receive count saturates: valids past the block size are ignored
  assign w_recv_inc     = i_run & i_data_valid & (r_recv < FULL);
  assign o_recv_last    = w_recv_inc & (r_recv == LAST);
  assign o_issue        = r_issue[OFF_W-1:0];
  assign o_recv         = r_recv[OFF_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_issue <= '0;
      r_recv  <= '0;
    end else begin
      if (w_issue_inc) r_issue <= r_issue + 1'b1;
      if (w_recv_inc)  r_recv  <= r_recv + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants main memory to I-cache fill or D-cache fill/write,
// sequences 8-word bursts and steers valid/done/fill_word to the owner.
// Ports: clk, rst (sync, high); ic_req/ic_addr -> ic_grant/valid/done;
//   dc_req/dc_wr/dc_addr/dc_wdata -> dc_grant/valid/done; fill_word;
//   mem_enable/mem_wr/mem_addr/mem_wdata, mem_data_valid.
// Option MEM_ARB_RR_EN: round-robin arbitration instead of D-cache first.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_grant,
  output logic              ic_valid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [15:0]       dc_wdata,
  output logic              dc_grant,
  output logic              dc_valid,
  output logic              dc_done,
  output logic [OFF_W-1:0]  fill_word,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_ic_done;
  logic              r_dc_done;
  logic              w_dc_win;
  logic              w_take;
  logic              w_ic_fill;
  logic              w_dc_fill;
  logic              w_fill;
  logic              w_write;
  logic              w_done_evt;
  logic [OFF_W-1:0]  w_issue;
  logic [OFF_W-1:0]  w_recv;
  logic              w_issue_active;
  logic              w_recv_last;

  assign w_ic_fill  = (r_state == IC_FILL);
  assign w_dc_fill  = (r_state == DC_FILL);
  assign w_write    = (r_state == DC_WRITE);
  assign w_fill     = w_ic_fill | w_dc_fill;
  assign w_done_evt = (w_fill & w_recv_last) | w_write;
  assign w_take     = (r_state == IDLE) & (ic_req | dc_req);

`ifdef MEM_ARB_RR_EN
  // set after a D-cache transaction: I-cache wins the next tie
  logic r_ic_prio;

  assign w_dc_win = dc_req & (~ic_req | ~r_ic_prio);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic_prio <= 1'b0;
    end else if (w_done_evt) begin
      r_ic_prio <= ~w_ic_fill;
    end
  end
`else
  assign w_dc_win = dc_req;
`endif

  arb_burst_counter u_cnt (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clear        (r_state == IDLE),
    .i_run          (w_fill),
    .i_data_valid   (mem_data_valid),
    .o_issue        (w_issue),
    .o_recv         (w_recv),
    .o_issue_active (w_issue_active),
    .o_recv_last    (w_recv_last)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_dc_win)    w_next = dc_wr ? DC_WRITE : DC_FILL;
        else if (ic_req) w_next = IC_FILL;
      end
      IC_FILL,
      DC_FILL: begin
        if (w_recv_last) w_next = IDLE;
      end
      DC_WRITE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ic_done <= 1'b0;
      r_dc_done <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ic_done <= w_ic_fill & w_recv_last;
      r_dc_done <= (w_dc_fill & w_recv_last) | w_write;
      if (w_take) begin
        r_addr  <= w_dc_win ? dc_addr : ic_addr;
        r_wdata <= (w_dc_win & dc_wr) ? dc_wdata : '0;
      end
    end
  end

  assign ic_grant  = w_ic_fill;
  assign dc_grant  = w_dc_fill | w_write;
  assign ic_valid  = w_ic_fill & mem_data_valid;
  assign dc_valid  = w_dc_fill & mem_data_valid;
  assign ic_done   = r_ic_done;
  assign dc_done   = r_dc_done;
  assign fill_word = w_fill ? w_recv : '0;

  always_comb begin
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (w_fill && w_issue_active) begin
      mem_enable = 1'b1;
      mem_addr   = {r_addr[ADDR_W-1:OFF_W+1], w_issue, 1'b0};
    end else if (w_write) begin
      mem_enable = 1'b1;
      mem_wr     = 1'b1;
      mem_addr   = r_addr;
      mem_wdata  = r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Latency-configurable memory model plus cycle-level expected outputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req = 1'b0;
  logic [15:0] ic_addr = '0;
  logic        ic_grant, ic_valid, ic_done;
  logic        dc_req = 1'b0;
  logic        dc_wr = 1'b0;
  logic [15:0] dc_addr = '0;
  logic [15:0] dc_wdata = '0;
  logic        dc_grant, dc_valid, dc_done;
  logic [2:0]  fill_word;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int lat   = 4;
  logic inject = 1'b0;
  bit m_ic_prio = 1'b0;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_grant       (ic_grant),
    .ic_valid       (ic_valid),
    .ic_done        (ic_done),
    .dc_req         (dc_req),
    .dc_wr          (dc_wr),
    .dc_addr        (dc_addr),
    .dc_wdata       (dc_wdata),
    .dc_grant       (dc_grant),
    .dc_valid       (dc_valid),
    .dc_done        (dc_done),
    .fill_word      (fill_word),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid)
  );

  always #5 clk = ~clk;

  // memory model: a read issued in cycle c returns in cycle c+lat
  int   cyc = 0;
  int   due_q[$];
  logic rd_seen = 1'b0;
  logic q_valid = 1'b0;

  always @(negedge clk) rd_seen <= mem_enable & ~mem_wr;

  always @(posedge clk) begin
    if (due_q.size() > 0 && due_q[0] == cyc)
      void'(due_q.pop_front());
    if (rd_seen)
      due_q.push_back(cyc + lat);
    q_valid <= (due_q.size() > 0 && due_q[0] == cyc + 1);
    cyc <= cyc + 1;
  end

  assign mem_data_valid = q_valid | inject;

  logic [42:0] w_obs;
  assign w_obs = {ic_grant, ic_valid, ic_done,
                  dc_grant, dc_valid, dc_done,
                  mem_enable, mem_wr, fill_word,
                  mem_addr, mem_wdata};

  // expected outputs k cycles after a fill request was sampled
  function automatic logic [42:0] fill_exp(
    input bit own_dc, input logic [15:0] a,
    input int l, input int k);
    logic g, en, v, d;
    logic [2:0]  fw;
    logic [15:0] ma;
    int idx;
    g   = (k >= 1) && (k <= 8 + l);
    en  = (k >= 1) && (k <= 8);
    v   = (k >= 1 + l) && (k <= 8 + l);
    d   = (k == 9 + l);
    idx = k - 1 - l;
    fw  = v ? idx[2:0] : 3'd0;
    ma  = en ? (a & 16'hFFF0) + 16'(2 * (k - 1)) : 16'h0;
    return {~own_dc & g, ~own_dc & v, ~own_dc & d,
            own_dc & g, own_dc & v, own_dc & d,
            en, 1'b0, fw, ma, 16'h0};
  endfunction

  function automatic bit model_dc_wins(input bit icr, input bit dcr);
    return dcr && (!icr || !m_ic_prio);
  endfunction

  task automatic note_owner(input bit own_dc);
`ifdef MEM_ARB_RR_EN
    m_ic_prio = own_dc;
`else
    m_ic_prio = 1'b0 & own_dc;
`endif
  endtask

  // request must already be driven; checks every cycle through done
  task automatic run_fill(input string nm, input bit own_dc,
                          input logic [15:0] a, input int drop_k,
                          input bit drop_both);
    logic [42:0] exp;
    for (int k = 1; k <= 9 + lat; k++) begin
      @(negedge clk);
      exp = fill_exp(own_dc, a, lat, k);
      n_cmp++;
      if (w_obs !== exp) begin
        n_bad++;
        $display("FAIL %s k=%0d got %h want %h", nm, k, w_obs, exp);
      end
      if (k == drop_k) begin
        if (own_dc) dc_req = 1'b0;
        else        ic_req = 1'b0;
      end
      if (k == 9 + lat) begin
        if (own_dc || drop_both) dc_req = 1'b0;
        if (!own_dc || drop_both) ic_req = 1'b0;
      end
    end
    note_owner(own_dc);
  endtask

  task automatic run_write(input string nm, input logic [15:0] a,
                           input logic [15:0] d);
    logic [42:0] exp;
    dc_req = 1'b1;
    dc_wr = 1'b1;
    dc_addr = a;
    dc_wdata = d;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (k == 1) exp = {6'b000100, 2'b11, 3'd0, a, d};
      else        exp = {6'b000001, 2'b00, 3'd0, 32'h0};
      n_cmp++;
      if (w_obs !== exp) begin
        n_bad++;
        $display("FAIL %s k=%0d got %h want %h", nm, k, w_obs, exp);
      end
      inject = 1'b0;
    end
    dc_req = 1'b0;
    dc_wr = 1'b0;
    note_owner(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (w_obs !== 43'h0) begin
        n_bad++;
        $display("FAIL reset got %h want 0", w_obs);
      end
    end
    rst = 1'b0;
    m_ic_prio = 1'b0;
  endtask

  task automatic test_ic_fill();
    lat = 4;
    ic_addr = 16'h1236;
    dc_addr = 16'($urandom);
    ic_req = 1'b1;
    run_fill("ic_fill", 1'b0, 16'h1236, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_write();
    inject = 1'b1;
    run_write("dc_write", 16'h0044, 16'hBEEF);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    lat = 2;
    run_write("b2b_wr", 16'($urandom), 16'($urandom));
    ic_addr = 16'($urandom);
    ic_req = 1'b1;
    run_fill("b2b_ic", 1'b0, ic_addr, 0, 1'b0);
    dc_addr = 16'($urandom);
    dc_wr = 1'b0;
    dc_req = 1'b1;
    run_fill("b2b_dc", 1'b1, dc_addr, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 2);
      lat = $urandom_range(1, 6);
      ic_addr = 16'($urandom);
      dc_addr = 16'($urandom);
      if (kind == 2) begin
        run_write("rnd_wr", dc_addr, 16'($urandom));
      end else if (kind == 1) begin
        dc_wr = 1'b0;
        dc_req = 1'b1;
        run_fill("rnd_dc", 1'b1, dc_addr, 0, 1'b0);
      end else begin
        ic_req = 1'b1;
        run_fill("rnd_ic", 1'b0, ic_addr, 0, 1'b0);
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_ic_drop();
    lat = 3;
    ic_addr = 16'hA5A2;
    ic_req = 1'b1;
    run_fill("ic_drop", 1'b0, 16'hA5A2, 3, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    bit w;
    for (int r = 0; r < 4; r++) begin
      lat = $urandom_range(1, 5);
      ic_addr = 16'($urandom);
      dc_addr = 16'($urandom);
      dc_wr = 1'b0;
      ic_req = 1'b1;
      dc_req = 1'b1;
      w = model_dc_wins(1'b1, 1'b1);
      run_fill("arb_rr", w, w ? dc_addr : ic_addr, 0, 1'b1);
      @(negedge clk);
    end
    ic_addr = 16'($urandom);
    dc_addr = 16'($urandom);
    ic_req = 1'b1;
    dc_req = 1'b1;
    w = model_dc_wins(1'b1, 1'b1);
    run_fill("arb_first", w, w ? dc_addr : ic_addr, 0, 1'b0);
    run_fill("arb_second", ~w, w ? ic_addr : dc_addr, 0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill();
    logic [42:0] exp;
    lat = 3;
    ic_addr = 16'h3C00;
    ic_req = 1'b1;
    for (int k = 1; k <= 5 + lat; k++) begin
      @(negedge clk);
      exp = fill_exp(1'b0, 16'h3C00, lat, k);
      n_cmp++;
      if (w_obs !== exp) begin
        n_bad++;
        $display("FAIL pre_rst k=%0d got %h want %h", k, w_obs, exp);
      end
    end
    rst = 1'b1;
    ic_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_obs !== 43'h0) begin
      n_bad++;
      $display("FAIL mid_rst got %h want 0", w_obs);
    end
    rst = 1'b0;
    m_ic_prio = 1'b0;
    run_write("post_rst", 16'h0BAD, 16'hCAFE);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (w_obs !== 43'h0) begin
        n_bad++;
        $display("FAIL late_valid i=%0d got %h want 0", i, w_obs);
      end
    end
    lat = 2;
    dc_addr = 16'h7770;
    dc_req = 1'b1;
    run_fill("post_rst_fill", 1'b1, 16'h7770, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ic_fill();
    test_write();
    test_back_to_back();
    test_random();
    test_ic_drop();
    test_arbitration();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
